// File: rtl/morra_pkg.sv
// rtl/morra_pkg.sv - shared encodings and constants for the morra cinese referee
package morra_pkg;

    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_e;

    // Shared by the per-manche and the per-match result outputs
    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_TIE  = 2'b11
    } result_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam logic [4:0] MIN_MANCHE  = 5'd4;
    localparam logic [4:0] LEAD_TO_WIN = 5'd2;

endpackage

// File: rtl/morra_judge.sv
// rtl/morra_judge.sv - combinational judge of a single manche
module morra_judge
    import morra_pkg::*;
(
    input  move_e   p1_move,
    input  move_e   p2_move,
    input  result_e last_winner,
    input  move_e   last_move,
    output logic    valid,
    output result_e result,
    output move_e   win_move
);

    logic p1_beats;
    logic repeat_move;

    always_comb begin
        valid    = 1'b0;
        result   = RES_NONE;
        win_move = MV_NONE;

        p1_beats = (p1_move == MV_ROCK     && p2_move == MV_SCISSORS) ||
                   (p1_move == MV_PAPER    && p2_move == MV_ROCK)     ||
                   (p1_move == MV_SCISSORS && p2_move == MV_PAPER);

        // The previous winner may not reuse the move it just won with
        repeat_move = (last_winner == RES_P1 && p1_move == last_move) ||
                      (last_winner == RES_P2 && p2_move == last_move);

        if (p1_move != MV_NONE && p2_move != MV_NONE && !repeat_move) begin
            valid = 1'b1;
            if (p1_move == p2_move) begin
                result = RES_TIE;
            end else if (p1_beats) begin
                result   = RES_P1;
                win_move = p1_move;
            end else begin
                result   = RES_P2;
                win_move = p2_move;
            end
        end
    end

endmodule

// File: rtl/morra_cinese.sv
// rtl/morra_cinese.sv - rock-paper-scissors match referee: FSM, counters, end-of-match
module morra_cinese
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       START,
    input  logic [1:0] P1,
    input  logic [1:0] P2,
    output logic [1:0] ROUND,
    output logic [1:0] GAME
);

    state_e     state_q, state_d;
    logic [4:0] max_q, max_d;
    logic [4:0] played_q, played_d;
    logic [4:0] p1_wins_q, p1_wins_d;
    logic [4:0] p2_wins_q, p2_wins_d;
    result_e    last_winner_q, last_winner_d;
    move_e      last_move_q, last_move_d;
    result_e    round_q, round_d;
    result_e    game_q, game_d;

    logic    judge_valid;
    result_e judge_result;
    move_e   judge_win_move;

    morra_judge u_judge (
        .p1_move     (move_e'(P1)),
        .p2_move     (move_e'(P2)),
        .last_winner (last_winner_q),
        .last_move   (last_move_q),
        .valid       (judge_valid),
        .result      (judge_result),
        .win_move    (judge_win_move)
    );

    always_comb begin
        state_d       = state_q;
        max_d         = max_q;
        played_d      = played_q;
        p1_wins_d     = p1_wins_q;
        p2_wins_d     = p2_wins_q;
        last_winner_d = last_winner_q;
        last_move_d   = last_move_q;
        round_d       = RES_NONE;
        game_d        = RES_NONE;

        if (START) begin
            state_d       = ST_PLAY;
            max_d         = MIN_MANCHE + {1'b0, P1, P2};
            played_d      = 5'd0;
            p1_wins_d     = 5'd0;
            p2_wins_d     = 5'd0;
            last_winner_d = RES_NONE;
            last_move_d   = MV_NONE;
        end else if (state_q == ST_PLAY && judge_valid) begin
            played_d = played_q + 5'd1;
            if (judge_result == RES_P1) p1_wins_d = p1_wins_q + 5'd1;
            if (judge_result == RES_P2) p2_wins_d = p2_wins_q + 5'd1;
            last_winner_d = (judge_result == RES_TIE) ? RES_NONE : judge_result;
            last_move_d   = judge_win_move;
            round_d       = judge_result;

            // A clear lead ends the match early; otherwise it runs to max
            if (played_d >= MIN_MANCHE &&
                (p1_wins_d >= p2_wins_d + LEAD_TO_WIN ||
                 p2_wins_d >= p1_wins_d + LEAD_TO_WIN)) begin
                game_d = (p1_wins_d > p2_wins_d) ? RES_P1 : RES_P2;
            end else if (played_d == max_q) begin
                if (p1_wins_d > p2_wins_d)      game_d = RES_P1;
                else if (p2_wins_d > p1_wins_d) game_d = RES_P2;
                else                            game_d = RES_TIE;
            end

            if (game_d != RES_NONE) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            max_q         <= 5'd0;
            played_q      <= 5'd0;
            p1_wins_q     <= 5'd0;
            p2_wins_q     <= 5'd0;
            last_winner_q <= RES_NONE;
            last_move_q   <= MV_NONE;
            round_q       <= RES_NONE;
            game_q        <= RES_NONE;
        end else begin
            state_q       <= state_d;
            max_q         <= max_d;
            played_q      <= played_d;
            p1_wins_q     <= p1_wins_d;
            p2_wins_q     <= p2_wins_d;
            last_winner_q <= last_winner_d;
            last_move_q   <= last_move_d;
            round_q       <= round_d;
            game_q        <= game_d;
        end
    end

    assign ROUND = round_q;
    assign GAME  = game_q;

endmodule

// File: tb/tb_morra_cinese.sv
// tb/tb_morra_cinese.sv - self-checking bench for the morra cinese referee
module tb_morra_cinese;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       START = 1'b0;
    logic [1:0] P1 = 2'b00;
    logic [1:0] P2 = 2'b00;
    logic [1:0] ROUND;
    logic [1:0] GAME;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_active, m_max, m_played, m_w1, m_w2, m_lw, m_lm;
    int exp_r = 0;
    int exp_g = 0;

    morra_cinese dut (
        .clk   (clk),
        .rst   (rst),
        .START (START),
        .P1    (P1),
        .P2    (P2),
        .ROUND (ROUND),
        .GAME  (GAME)
    );

    always #5 clk = ~clk;

    // rock=1, paper=2, scissors=3: a beats b when a is one step ahead cyclically
    function automatic bit beats(input int a, input int b);
        return ((a - b + 3) % 3) == 1;
    endfunction

    task automatic model_step(input int r, input int s, input int a, input int b);
        exp_r = 0;
        exp_g = 0;
        if (r != 0) begin
            m_active = 0; m_max = 0; m_played = 0; m_w1 = 0; m_w2 = 0; m_lw = 0; m_lm = 0;
        end else if (s != 0) begin
            m_active = 1; m_max = 4 + a * 4 + b;
            m_played = 0; m_w1 = 0; m_w2 = 0; m_lw = 0; m_lm = 0;
        end else if (m_active != 0 && a != 0 && b != 0 &&
                     !(m_lw == 1 && a == m_lm) && !(m_lw == 2 && b == m_lm)) begin
            m_played++;
            if (a == b) begin
                exp_r = 3; m_lw = 0; m_lm = 0;
            end else if (beats(a, b)) begin
                exp_r = 1; m_w1++; m_lw = 1; m_lm = a;
            end else begin
                exp_r = 2; m_w2++; m_lw = 2; m_lm = b;
            end
            if (m_played >= 4 && (m_w1 - m_w2 >= 2 || m_w2 - m_w1 >= 2))
                exp_g = (m_w1 > m_w2) ? 1 : 2;
            else if (m_played == m_max)
                exp_g = (m_w1 > m_w2) ? 1 : ((m_w2 > m_w1) ? 2 : 3);
            if (exp_g != 0) m_active = 0;
        end
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            checks++;
            if (int'(ROUND) != exp_r) begin
                errors++;
                $display("FAIL round: got %0d expected %0d at %0t", ROUND, exp_r, $time);
            end
            checks++;
            if (int'(GAME) != exp_g) begin
                errors++;
                $display("FAIL game: got %0d expected %0d at %0t", GAME, exp_g, $time);
            end
        end
    end

    // lr/lg < 0 skip the hand-computed pin on the model's expectation
    task automatic cyc(input int r, input int s, input int a, input int b,
                       input int lr, input int lg);
        @(negedge clk);
        rst   = (r != 0);
        START = (s != 0);
        P1    = 2'(a);
        P2    = 2'(b);
        model_step(r, s, a, b);
        chk_en = 1'b1;
        @(posedge clk);
        #2;
        if (lr >= 0) begin
            checks++;
            if (exp_r != lr) begin
                errors++;
                $display("FAIL model_round: got %0d expected %0d at %0t", exp_r, lr, $time);
            end
        end
        if (lg >= 0) begin
            checks++;
            if (exp_g != lg) begin
                errors++;
                $display("FAIL model_game: got %0d expected %0d at %0t", exp_g, lg, $time);
            end
        end
    endtask

    initial begin
        m_active = 0; m_max = 0; m_played = 0; m_w1 = 0; m_w2 = 0; m_lw = 0; m_lm = 0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 0, 0);
        cyc(0, 1, 3, 1, 0, 0);
        cyc(0, 0, 3, 2, 1, 0);
        cyc(0, 0, 1, 1, 3, 0);
        cyc(0, 0, 0, 3, 0, 0);
        cyc(0, 0, 3, 2, 1, 0);
        cyc(0, 0, 3, 2, 0, 0);
        cyc(0, 0, 1, 3, 1, 1);
        cyc(0, 0, 3, 2, 0, 0);

        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 2, 1, 1, 0);
        cyc(0, 0, 3, 2, 1, 0);
        cyc(0, 0, 1, 3, 1, 1);
        cyc(0, 0, 2, 1, 0, 0);

        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 3, 1, 2, 0);
        cyc(0, 0, 2, 2, 3, 0);
        cyc(0, 0, 1, 1, 3, 3);

        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 3, 1, 2, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 2, 1, 1, 0);
        cyc(0, 0, 3, 2, 1, 0);
        cyc(0, 0, 1, 3, 1, 1);

        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(1, 0, 1, 3, 0, 0);
        cyc(0, 0, 2, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0) ? 1 : 0,
                ($urandom_range(0, 14) == 0) ? 1 : 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
